memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Memory-access pipeline stage. Consumes the execute_data_t record leaving EX and drives dbus
//  loads/stores via a valid/data_ok handshake. Aligns store data and strobes, extracts and
//  sign/zero-extends load data, and emits memory_data_t to writeback.
//  Raises a stall while a bus access is outstanding. Holds a completed access across hazard freezes.
// PARAMETERS
//  XLEN    64  datapath width; alu_out, srcb and dbus data width
//  BYTE_W  8   dbus byte lanes (= XLEN/8); strobe width
// PORTS
//  clk       in   1       pipeline clock
//  reset     in   1       synchronous, active-high reset
//  dataE     in   struct  execute_data_t: pc, alu_out, srcb, dst, ctl, valid
//  freeze    in   1       downstream/hazard freeze; dataM must not advance
//  flush     in   1       kill current EX->MEM record (no new request issued)
//  dreq      out  struct  dbus_req_t: valid, addr, size, strobe, data
//  dresp     in   struct  dbus_resp_t: addr_ok, data_ok, data
//  dataM     out  struct  memory_data_t: pc, result, dst, ctl, valid
//  stallM    out  1       access in flight; upstream stages hold
//  misalign  out  1       misaligned access flagged (0 unless MEM_MISALIGN_CHECK_EN)
// BEHAVIOUR
//  - Mem op = dataE.valid & (ctl.memread | ctl.memwrite) & !flush. Non-mem ops pass straight through
//    with 0 latency: result=alu_out, no dreq.
//  - addr = alu_out; off = addr[2:0].
//  - size from ctl.msize: B=1, H=2, W=4, D=8 bytes.
//  - Store: data = srcb << (off*8); strobe = ((1<<bytes)-1) << off. Load: strobe = 0.
//  - Load result: raw = dresp.data >> (off*8), truncated to msize.
//    Sign-extend unless ctl.mem_unsigned; then zero-extend.
//  - FSM states: IDLE, BUSY, HOLD. Reset -> IDLE.
//    - IDLE: on mem op, dreq.valid=1 combinationally. data_ok same cycle & !freeze -> complete, stay IDLE.
//      data_ok & freeze -> latch, HOLD. No data_ok -> BUSY.
//    - BUSY: dreq held stable from a registered copy; EX changes are ignored.
//      data_ok & !freeze -> IDLE; data_ok & freeze -> HOLD (latch raw data).
//      flush is ignored: an issued access always completes.
//    - HOLD: dreq.valid=0; dataM from latched result. !freeze -> IDLE.
//  - stallM = (IDLE & mem op & !data_ok) | (BUSY & !data_ok). Not asserted in HOLD; freeze covers it.
//  - dataM.valid = dataE.valid & !stallM & !flush. The HOLD copy is valid=1 until released.
//  - addr_ok is informational only; completion is defined solely by data_ok.
//  - Reset outputs: dreq.valid=0, strobe=0, stallM=0, misalign=0, dataM.valid=0, latched regs 0.
//    Reset mid-access drops dreq.valid next cycle. The bus shares this reset.
//  - Simultaneous data_ok and reset: reset wins; the response is discarded.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//    - addr not a multiple of the access size -> no dreq, misalign=1 for that cycle, stallM=0.
//    - Stores suppressed (strobe=0); dataM.ctl carries the flag for the trap logic.
//  Undefined:
//    - misalign tied 0; all accesses are issued as computed. Bytes shifted past lane 7 are dropped.
// TESTING
//  - ld addr 0x80000010, data_ok after 3 cycles, data 0x1122334455667788
//    -> stallM high 3 cycles, then result 0x1122334455667788.
//  - lb addr 0x80000003, resp data 0x00000000_F0000000 -> result 0xFFFFFFFFFFFFFFF0.
//    Same with lbu -> result 0x00000000000000F0.
//  - sh srcb 0xABCD addr 0x80000006 -> dreq.data[63:48]=0xABCD, strobe=8'b1100_0000, size=H.
//  - data_ok arrives with freeze=1 for 2 cycles -> FSM enters HOLD.
//    dataM.result stays stable, no second dreq; IDLE when freeze drops.
//  - reset asserted in BUSY -> next cycle dreq.valid=0, stallM=0, dataM.valid=0, state IDLE.
//  - MEM_MISALIGN_CHECK_EN: sw addr 0x80000002 -> misalign=1, dreq.valid=0, no stall.
//    Undefined: the store is issued with strobe=8'b0011_1100.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage_pkg / memory_stage
//
// Memory-access pipeline stage. Takes the EX record and issues dbus loads and stores
// using a valid/data_ok handshake. It aligns store data and byte strobes to the bus
// lanes, and it extracts and sign- or zero-extends load data. The result goes to
// writeback as a memory_data_t.
//
// Ports:
//   clk_i      pipeline clock
//   reset_i    synchronous, active-high reset (shared with the bus)
//   dataE_i    execute_data_t from EX
//   freeze_i   downstream/hazard freeze; a completed access is parked in HOLD
//   flush_i    kill the current EX record in IDLE (an issued access still completes)
//   dreq_o     dbus request: valid, addr, size, strobe, data
//   dresp_i    dbus response: addr_ok (unused), data_ok, data
//   dataM_o    memory_data_t to writeback
//   stallM_o   access in flight; upstream holds
//   misalign_o misaligned access flagged
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to block misaligned accesses.
// A blocked access raises misalign_o and sets dataM.ctl.misalign.
package memory_stage_pkg;
  localparam int XLEN   = 64;
  localparam int BYTE_W = XLEN / 8;

  typedef enum logic [1:0] {MSIZE_B = 2'd0, MSIZE_H = 2'd1, MSIZE_W = 2'd2, MSIZE_D = 2'd3} msize_e;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   mem_unsigned;
    msize_e msize;
    logic   misalign;
  } ctl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] srcb;
    logic [4:0]      dst;
    ctl_t            ctl;
    logic            valid;
  } execute_data_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic [4:0]      dst;
    ctl_t            ctl;
    logic            valid;
  } memory_data_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   addr;
    msize_e            size;
    logic [BYTE_W-1:0] strobe;
    logic [XLEN-1:0]   data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  execute_data_t dataE_i,
  input  logic          freeze_i,
  input  logic          flush_i,
  output dbus_req_t     dreq_o,
  input  dbus_resp_t    dresp_i,
  output memory_data_t  dataM_o,
  output logic          stallM_o,
  output logic          misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e        state_q, state_d;
  dbus_req_t     req_q, req_d;     // request replayed verbatim while BUSY
  execute_data_t rec_q, rec_d;     // EX record captured at issue; EX may change while BUSY
  memory_data_t  hold_q, hold_d;   // completed result parked across a freeze

  logic unused_addr_ok;
  assign unused_addr_ok = dresp_i.addr_ok;

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input logic [2:0] off,
                                               input msize_e sz, input logic uns);
    logic [XLEN-1:0] raw;
    raw = d >> {off, 3'b000};
    case (sz)
      MSIZE_B: load_ext = uns ? {{(XLEN-8){1'b0}}, raw[7:0]}   : {{(XLEN-8){raw[7]}}, raw[7:0]};
      MSIZE_H: load_ext = uns ? {{(XLEN-16){1'b0}}, raw[15:0]} : {{(XLEN-16){raw[15]}}, raw[15:0]};
      MSIZE_W: load_ext = uns ? {{(XLEN-32){1'b0}}, raw[31:0]} : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: load_ext = raw;
    endcase
  endfunction

  logic              mem_op, misal;
  logic [2:0]        off;
  logic [BYTE_W-1:0] bmask;
  dbus_req_t         new_req, req_c;
  execute_data_t     cur;
  memory_data_t      res_c;
  logic [XLEN-1:0]   mem_result;

  assign mem_op = dataE_i.valid & (dataE_i.ctl.memread | dataE_i.ctl.memwrite) & ~flush_i;
  assign off    = dataE_i.alu_out[2:0];

  always_comb begin
    case (dataE_i.ctl.msize)
      MSIZE_B: bmask = 8'h01;
      MSIZE_H: bmask = 8'h03;
      MSIZE_W: bmask = 8'h0F;
      default: bmask = 8'hFF;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    case (dataE_i.ctl.msize)
      MSIZE_B: misal = 1'b0;
      MSIZE_H: misal = off[0];
      MSIZE_W: misal = |off[1:0];
      default: misal = |off;
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  // Lane alignment: bytes pushed past the top lane are simply dropped.
  always_comb begin
    new_req        = '0;
    new_req.valid  = 1'b1;
    new_req.addr   = dataE_i.alu_out;
    new_req.size   = dataE_i.ctl.msize;
    new_req.strobe = dataE_i.ctl.memwrite ? (bmask << off) : '0;
    new_req.data   = dataE_i.ctl.memwrite ? (dataE_i.srcb << {off, 3'b000}) : '0;
  end

  assign cur        = (state_q == BUSY) ? rec_q : dataE_i;
  assign mem_result = cur.ctl.memread
                      ? load_ext(dresp_i.data, cur.alu_out[2:0], cur.ctl.msize, cur.ctl.mem_unsigned)
                      : cur.alu_out;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rec_d        = rec_q;
    hold_d       = hold_q;
    req_c        = '0;
    stallM_o     = 1'b0;
    misalign_o   = 1'b0;
    res_c.pc     = dataE_i.pc;
    res_c.result = dataE_i.alu_out;
    res_c.dst    = dataE_i.dst;
    res_c.ctl    = dataE_i.ctl;
    res_c.valid  = dataE_i.valid & ~flush_i;
    case (state_q)
      IDLE: begin
        if (mem_op && misal) begin
          misalign_o         = 1'b1;
          res_c.ctl.misalign = 1'b1;
        end else if (mem_op) begin
          req_c = new_req;
          if (dresp_i.data_ok) begin
            res_c.result = mem_result;
            if (freeze_i) begin
              hold_d  = res_c;
              state_d = HOLD;
            end
          end else begin
            stallM_o    = 1'b1;
            res_c.valid = 1'b0;
            req_d       = new_req;
            rec_d       = dataE_i;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        req_c = req_q;
        res_c = '{pc: rec_q.pc, result: mem_result, dst: rec_q.dst, ctl: rec_q.ctl, valid: 1'b1};
        if (dresp_i.data_ok) begin
          if (freeze_i) begin
            hold_d  = res_c;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stallM_o    = 1'b1;
          res_c.valid = 1'b0;
        end
      end
      default: begin // HOLD
        res_c = hold_q;
        if (!freeze_i) state_d = IDLE;
      end
    endcase
    dreq_o  = req_c;
    dataM_o = res_c;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      rec_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rec_q   <= rec_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          freeze, flush;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          stallM, misalign;

  int cmps = 0;
  int errs = 0;

  memory_stage dut (
    .clk_i(clk), .reset_i(reset), .dataE_i(dataE), .freeze_i(freeze), .flush_i(flush),
    .dreq_o(dreq), .dresp_i(dresp), .dataM_o(dataM), .stallM_o(stallM), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  function automatic execute_data_t mk(input logic [63:0] alu, input logic [63:0] srcb,
                                       input logic rd, input logic wr, input logic uns, input msize_e sz);
    execute_data_t e;
    e = '0;
    e.pc = 64'h8000_1000;
    e.alu_out = alu;
    e.srcb = srcb;
    e.dst = 5'd7;
    e.ctl.regwrite = rd;
    e.ctl.memread = rd;
    e.ctl.memwrite = wr;
    e.ctl.mem_unsigned = uns;
    e.ctl.msize = sz;
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    cmps++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; dataE = '0; freeze = 1'b0; flush = 1'b0; dresp = '0;
    tick; tick;
    reset = 1'b0;
    #1;
    chk("reset dreq.valid", 64'(dreq.valid), 64'd0);
    chk("reset strobe", 64'(dreq.strobe), 64'd0);
    chk("reset stallM", 64'(stallM), 64'd0);
    chk("reset misalign", 64'(misalign), 64'd0);
    chk("reset dataM.valid", 64'(dataM.valid), 64'd0);
  endtask

  task automatic test_passthrough;
    tick;
    dataE = mk(64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 1'b0, 1'b0, MSIZE_D);
    #1;
    chk("alu result", dataM.result, 64'h1234_5678_9ABC_DEF0);
    chk("alu valid", 64'(dataM.valid), 64'd1);
    chk("alu no dreq", 64'(dreq.valid), 64'd0);
    chk("alu no stall", 64'(stallM), 64'd0);
    flush = 1'b1;
    #1;
    chk("flush valid", 64'(dataM.valid), 64'd0);
    dataE = mk(64'h8000_0010, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE_D);
    #1;
    chk("flush ld no dreq", 64'(dreq.valid), 64'd0);
    chk("flush ld no stall", 64'(stallM), 64'd0);
    flush = 1'b0;
  endtask

  task automatic test_ld_latency;
    int stalls;
    tick;
    stalls = 0;
    dataE = mk(64'h8000_0010, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE_D);
    #1;
    chk("ld dreq.valid", 64'(dreq.valid), 64'd1);
    chk("ld addr", dreq.addr, 64'h8000_0010);
    chk("ld size", 64'(dreq.size), 64'(MSIZE_D));
    chk("ld strobe", 64'(dreq.strobe), 64'd0);
    chk("ld dataM.valid stalled", 64'(dataM.valid), 64'd0);
    if (stallM) stalls++;
    tick;
    dataE.alu_out = 64'h0000_0000_DEAD_0000;
    #1;
    chk("busy addr stable", dreq.addr, 64'h8000_0010);
    chk("busy dreq.valid", 64'(dreq.valid), 64'd1);
    if (stallM) stalls++;
    tick;
    if (stallM) stalls++;
    tick;
    dresp.data_ok = 1'b1;
    dresp.data = 64'h1122_3344_5566_7788;
    #1;
    chk("ld stall cycles", 64'(stalls), 64'd3);
    chk("ld done stall", 64'(stallM), 64'd0);
    chk("ld result", dataM.result, 64'h1122_3344_5566_7788);
    chk("ld valid", 64'(dataM.valid), 64'd1);
    tick;
    dresp = '0;
    dataE = '0;
    #1;
    chk("ld back idle", 64'(dreq.valid), 64'd0);
  endtask

  task automatic test_lb;
    tick;
    dataE = mk(64'h8000_0003, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE_B);
    dresp.data_ok = 1'b1;
    dresp.data = 64'h0000_0000_F000_0000;
    #1;
    chk("lb result", dataM.result, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("lb no stall", 64'(stallM), 64'd0);
    tick;
    dataE.ctl.mem_unsigned = 1'b1;
    #1;
    chk("lbu result", dataM.result, 64'h0000_0000_0000_00F0);
    tick;
    dataE = mk(64'h8000_0004, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE_H);
    dresp.data = 64'h0000_8001_0000_0000;
    #1;
    chk("lh result", dataM.result, 64'hFFFF_FFFF_FFFF_8001);
    tick;
    dresp = '0;
    dataE = '0;
  endtask

  task automatic test_sh;
    tick;
    dataE = mk(64'h8000_0006, 64'h0000_0000_0000_ABCD, 1'b0, 1'b1, 1'b0, MSIZE_H);
    dresp.data_ok = 1'b1;
    #1;
    chk("sh dreq.valid", 64'(dreq.valid), 64'd1);
    chk("sh data hi", 64'(dreq.data[63:48]), 64'hABCD);
    chk("sh strobe", 64'(dreq.strobe), 64'hC0);
    chk("sh size", 64'(dreq.size), 64'(MSIZE_H));
    tick;
    dresp = '0;
    dataE = '0;
  endtask

  task automatic test_hold;
    tick;
    dataE = mk(64'h8000_0008, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE_D);
    #1;
    chk("hold issue stall", 64'(stallM), 64'd1);
    tick;
    freeze = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data = 64'hCAFE_F00D_0BAD_BEEF;
    #1;
    chk("hold complete result", dataM.result, 64'hCAFE_F00D_0BAD_BEEF);
    tick;
    dresp = '0;
    #1;
    chk("hold no dreq", 64'(dreq.valid), 64'd0);
    chk("hold result stable", dataM.result, 64'hCAFE_F00D_0BAD_BEEF);
    chk("hold valid", 64'(dataM.valid), 64'd1);
    chk("hold no stall", 64'(stallM), 64'd0);
    tick;
    freeze = 1'b0;
    #1;
    chk("hold release result", dataM.result, 64'hCAFE_F00D_0BAD_BEEF);
    chk("hold release no dreq", 64'(dreq.valid), 64'd0);
    tick;
    dataE = mk(64'h0000_0000_0000_0042, 64'h0, 1'b0, 1'b0, 1'b0, MSIZE_D);
    #1;
    chk("after hold idle result", dataM.result, 64'h42);
    tick;
    dataE = '0;
  endtask

  task automatic test_reset_busy;
    tick;
    dataE = mk(64'h8000_0020, 64'h0, 1'b1, 1'b0, 1'b0, MSIZE_D);
    #1;
    chk("rb issue", 64'(dreq.valid), 64'd1);
    tick;
    reset = 1'b1;
    dataE = '0;
    dresp.data_ok = 1'b1;
    dresp.data = 64'hDEAD_DEAD_DEAD_DEAD;
    tick;
    reset = 1'b0;
    dresp = '0;
    #1;
    chk("rb dreq.valid", 64'(dreq.valid), 64'd0);
    chk("rb stallM", 64'(stallM), 64'd0);
    chk("rb dataM.valid", 64'(dataM.valid), 64'd0);
    tick;
    dataE = mk(64'h55, 64'h0, 1'b0, 1'b0, 1'b0, MSIZE_D);
    #1;
    chk("rb idle result", dataM.result, 64'h55);
    tick;
    dataE = '0;
  endtask

  task automatic test_misalign;
    tick;
    dataE = mk(64'h8000_0002, 64'h0000_0000_1122_3344, 1'b0, 1'b1, 1'b0, MSIZE_W);
    dresp.data_ok = 1'b1;
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    chk("sw misalign flag", 64'(misalign), 64'd1);
    chk("sw misalign no dreq", 64'(dreq.valid), 64'd0);
    chk("sw misalign no stall", 64'(stallM), 64'd0);
    chk("sw misalign ctl", 64'(dataM.ctl.misalign), 64'd1);
`else
    chk("sw misalign off", 64'(misalign), 64'd0);
    chk("sw dreq.valid", 64'(dreq.valid), 64'd1);
    chk("sw strobe", 64'(dreq.strobe), 64'h3C);
    chk("sw data", dreq.data, 64'h0000_1122_3344_0000);
`endif
    tick;
    dresp = '0;
    dataE = '0;
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_ld_latency;
    test_lb;
    test_sh;
    test_hold;
    test_reset_busy;
    test_misalign;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
